// File: rtl/cpu_pkg.sv
// Shared encodings for the 8-bit accumulator CPU control path: opcodes,
// ALU operation codes, sequencer states and instruction field positions.
package cpu_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_STA  = 4'h5;
  localparam logic [3:0] OP_BRN  = 4'hA;
  localparam logic [3:0] OP_SHL  = 4'hB;
  localparam logic [3:0] OP_LDI  = 4'hD;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [1:0] ALU_PASS = 2'b00;
  localparam logic [1:0] ALU_ADD  = 2'b01;
  localparam logic [1:0] ALU_SUB  = 2'b10;
  localparam logic [1:0] ALU_SHL  = 2'b11;

  localparam int unsigned OPC_MSB = 7;
  localparam int unsigned OPC_LSB = 4;
  localparam int unsigned OPR_MSB = 3;
  localparam int unsigned OPR_LSB = 0;

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_DECODE  = 2'd1,
    S_EXECUTE = 2'd2,
    S_HALT    = 2'd3
  } state_t;

endpackage

// File: rtl/cpu_decoder.sv
// Combinational opcode decoder: maps the 4-bit opcode to ALU control,
// write enables and branch/halt flags. Unlisted opcodes decode as NOP.
module cpu_decoder
  import cpu_pkg::*;
(
  input  logic [3:0] opcode,
  output logic [1:0] alu_op,
  output logic       acc_src,
  output logic       acc_we_en,
  output logic       reg_we_en,
  output logic       is_branch,
  output logic       is_halt
);

  always_comb begin
    alu_op    = ALU_PASS;
    acc_src   = 1'b0;
    acc_we_en = 1'b0;
    reg_we_en = 1'b0;
    is_branch = 1'b0;
    is_halt   = 1'b0;
    case (opcode)
      OP_ADD:  begin alu_op = ALU_ADD; acc_we_en = 1'b1; end
      OP_SUB:  begin alu_op = ALU_SUB; acc_we_en = 1'b1; end
      OP_SHL:  begin alu_op = ALU_SHL; acc_we_en = 1'b1; end
      OP_LDI:  begin acc_src = 1'b1;   acc_we_en = 1'b1; end
      OP_STA:  reg_we_en = 1'b1;
      OP_BRN:  is_branch = 1'b1;
      OP_HALT: is_halt   = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_control_unit.sv
// Multi-cycle FETCH/DECODE/EXECUTE sequencer: owns the PC and instruction
// register and issues one-cycle datapath strobes during EXECUTE.
module cpu_control_unit
  import cpu_pkg::*;
#(
  parameter int unsigned PC_WIDTH    = 8,
  parameter int unsigned INSTR_WIDTH = 8,
  parameter int unsigned RESET_PC    = 0
) (
  input  logic                   CLK,
  input  logic                   CLB,
  input  logic [INSTR_WIDTH-1:0] instr_in,
  input  logic                   acc_neg,
  output logic [PC_WIDTH-1:0]    pc_out,
  output logic [1:0]             alu_op,
  output logic                   acc_we,
  output logic                   acc_src,
  output logic                   reg_we,
  output logic [3:0]             reg_sel,
  output logic [3:0]             imm_out,
  output logic                   halted
);

  state_t                 state, state_nxt;
  logic [PC_WIDTH-1:0]    pc, pc_nxt;
  logic [INSTR_WIDTH-1:0] ir;
  logic [3:0]             opr_q;

  logic [1:0] dec_alu_op;
  logic       dec_acc_src, dec_acc_we_en, dec_reg_we_en, dec_is_branch, dec_is_halt;

  cpu_decoder u_dec (
    .opcode    (ir[OPC_MSB:OPC_LSB]),
    .alu_op    (dec_alu_op),
    .acc_src   (dec_acc_src),
    .acc_we_en (dec_acc_we_en),
    .reg_we_en (dec_reg_we_en),
    .is_branch (dec_is_branch),
    .is_halt   (dec_is_halt)
  );

  always_ff @(posedge CLK or negedge CLB) begin
    if (!CLB) begin
      state <= S_FETCH;
      pc    <= PC_WIDTH'(RESET_PC);
      ir    <= '0;
      opr_q <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (state == S_FETCH)  ir    <= instr_in;
      if (state == S_DECODE) opr_q <= ir[OPR_MSB:OPR_LSB];
    end
  end

  // Strobes are gated by state, so an async reset drops them immediately.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    alu_op    = ALU_PASS;
    acc_src   = 1'b0;
    acc_we    = 1'b0;
    reg_we    = 1'b0;
    halted    = 1'b0;
    case (state)
      S_FETCH: state_nxt = S_DECODE;
      S_DECODE: begin
        alu_op    = dec_alu_op;
        acc_src   = dec_acc_src;
        state_nxt = S_EXECUTE;
      end
      S_EXECUTE: begin
        alu_op  = dec_alu_op;
        acc_src = dec_acc_src;
        acc_we  = dec_acc_we_en;
        reg_we  = dec_reg_we_en;
        if (dec_is_halt) begin
          halted    = 1'b1;
          state_nxt = S_HALT;
        end else begin
          state_nxt = S_FETCH;
          if (dec_is_branch && acc_neg)
            pc_nxt = PC_WIDTH'(ir[OPR_MSB:OPR_LSB]);
          else
            pc_nxt = pc + PC_WIDTH'(1);
        end
      end
      S_HALT: halted = 1'b1;
      default: state_nxt = S_FETCH;
    endcase
  end

  assign pc_out  = pc;
  assign reg_sel = opr_q;
  assign imm_out = opr_q;

endmodule

// File: tb/tb_cpu_control_unit.sv
// Directed bench for cpu_control_unit: instruction memory model plus
// per-cycle checks of PC, strobes and decoded fields.
module tb_cpu_control_unit;

  logic       CLK = 1'b0;
  logic       CLB;
  logic [7:0] instr_in;
  logic       acc_neg;
  logic [7:0] pc_out;
  logic [1:0] alu_op;
  logic       acc_we, acc_src, reg_we;
  logic [3:0] reg_sel, imm_out;
  logic       halted;

  logic [7:0] imem [256];
  logic       ovr_en;
  logic [7:0] ovr_val;

  int total = 0;
  int bad   = 0;

  cpu_control_unit #(.PC_WIDTH(8), .INSTR_WIDTH(8), .RESET_PC(0)) dut (
    .CLK      (CLK),
    .CLB      (CLB),
    .instr_in (instr_in),
    .acc_neg  (acc_neg),
    .pc_out   (pc_out),
    .alu_op   (alu_op),
    .acc_we   (acc_we),
    .acc_src  (acc_src),
    .reg_we   (reg_we),
    .reg_sel  (reg_sel),
    .imm_out  (imm_out),
    .halted   (halted)
  );

  always #5 CLK = ~CLK;

  // Asynchronous-read instruction memory, with an override for junk input.
  always_comb instr_in = ovr_en ? ovr_val : imem[pc_out];

  function automatic logic [21:0] pk(input logic [7:0] pc, input logic [1:0] alu,
                                     input logic awe, input logic src, input logic rwe,
                                     input logic [3:0] sel, input logic [3:0] imm,
                                     input logic hlt);
    return {pc, alu, awe, src, rwe, sel, imm, hlt};
  endfunction

  task automatic chk(input string tag, input logic [21:0] exp);
    logic [21:0] obs;
    obs = pk(pc_out, alu_op, acc_we, acc_src, reg_we, reg_sel, imm_out, halted);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs={pc,alu,awe,src,rwe,sel,imm,hlt}=%06h exp=%06h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Entered while sampling the FETCH cycle; leaves sampling the next cycle.
  task automatic run_instr(input string tag, input logic [7:0] pc, input logic [3:0] prev,
                           input logic [1:0] alu, input logic src, input logic awe,
                           input logic rwe, input logic [3:0] opr, input logic hlt);
    chk({tag, ".F"}, pk(pc, 2'b00, 1'b0, 1'b0, 1'b0, prev, prev, 1'b0));
    tick();
    chk({tag, ".D"}, pk(pc, alu, 1'b0, src, 1'b0, prev, prev, 1'b0));
    tick();
    chk({tag, ".E"}, pk(pc, alu, awe, src, rwe, opr, opr, hlt));
    tick();
  endtask

  task automatic do_reset();
    @(negedge CLK);
    CLB = 1'b0;
    #2;
    chk("reset", pk(8'd0, 2'b00, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0));
    @(negedge CLK);
    CLB = 1'b1;
    #1;
  endtask

  initial begin
    CLB     = 1'b0;
    acc_neg = 1'b0;
    ovr_en  = 1'b0;
    ovr_val = 8'h00;
    for (int i = 0; i < 256; i++) imem[i] = 8'h00;
    imem[0] = 8'hD5; imem[1] = 8'h50; imem[2] = 8'hD3; imem[3] = 8'h51;
    imem[4] = 8'hD0; imem[5] = 8'h10; imem[6] = 8'h21;
    imem[13] = 8'hAF; imem[18] = 8'hF0;

    // Program 1: sequencing, branch taken, NOPs, halt
    #2;
    chk("reset0", pk(8'd0, 2'b00, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0));
    @(negedge CLK);
    CLB = 1'b1;
    #1;
    run_instr("ldi5", 8'd0, 4'h0, 2'b00, 1'b1, 1'b1, 1'b0, 4'h5, 1'b0);
    run_instr("sta0", 8'd1, 4'h5, 2'b00, 1'b0, 1'b0, 1'b1, 4'h0, 1'b0);
    run_instr("ldi3", 8'd2, 4'h0, 2'b00, 1'b1, 1'b1, 1'b0, 4'h3, 1'b0);
    run_instr("sta1", 8'd3, 4'h3, 2'b00, 1'b0, 1'b0, 1'b1, 4'h1, 1'b0);
    run_instr("ldi0", 8'd4, 4'h1, 2'b00, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
    run_instr("add0", 8'd5, 4'h0, 2'b01, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0);
    run_instr("sub1", 8'd6, 4'h0, 2'b10, 1'b0, 1'b1, 1'b0, 4'h1, 1'b0);
    run_instr("nop7", 8'd7, 4'h1, 2'b00, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
    for (int p = 8; p <= 12; p++)
      run_instr("nopa", 8'(p), 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
    acc_neg = 1'b1;
    run_instr("brn_t", 8'd13, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 4'hF, 1'b0);
    acc_neg = 1'b0;
    run_instr("nop15", 8'd15, 4'hF, 2'b00, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
    run_instr("nop16", 8'd16, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
    run_instr("nop17", 8'd17, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
    run_instr("halt", 8'd18, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1);
    ovr_en = 1'b1;
    for (int c = 0; c < 10; c++) begin
      ovr_val = 8'($urandom_range(0, 255));
      chk("halted", pk(8'd18, 2'b00, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1));
      tick();
    end
    ovr_en = 1'b0;

    // Program 1 again: async reset in the middle of ADD's EXECUTE
    do_reset();
    run_instr("r.ldi5", 8'd0, 4'h0, 2'b00, 1'b1, 1'b1, 1'b0, 4'h5, 1'b0);
    run_instr("r.sta0", 8'd1, 4'h5, 2'b00, 1'b0, 1'b0, 1'b1, 4'h0, 1'b0);
    run_instr("r.ldi3", 8'd2, 4'h0, 2'b00, 1'b1, 1'b1, 1'b0, 4'h3, 1'b0);
    run_instr("r.sta1", 8'd3, 4'h3, 2'b00, 1'b0, 1'b0, 1'b1, 4'h1, 1'b0);
    run_instr("r.ldi0", 8'd4, 4'h1, 2'b00, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
    chk("r.add.F", pk(8'd5, 2'b00, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0));
    tick();
    chk("r.add.D", pk(8'd5, 2'b01, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0));
    tick();
    chk("r.add.E", pk(8'd5, 2'b01, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0));
    #2;
    CLB = 1'b0;
    #1;
    chk("midrst", pk(8'd0, 2'b00, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0));
    #2;
    CLB = 1'b1;
    #1;
    // Full program from PC 0, this time with the branch not taken
    run_instr("n.ldi5", 8'd0, 4'h0, 2'b00, 1'b1, 1'b1, 1'b0, 4'h5, 1'b0);
    for (int p = 1; p <= 6; p++) repeat (3) tick();
    run_instr("n.nop7", 8'd7, 4'h1, 2'b00, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
    for (int p = 8; p <= 12; p++) repeat (3) tick();
    acc_neg = 1'b0;
    run_instr("brn_n", 8'd13, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 4'hF, 1'b0);
    run_instr("nop14", 8'd14, 4'hF, 2'b00, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
    run_instr("n.nop15", 8'd15, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);

    // Program 2: NOPs up to 255, undefined opcode 3A there, then wrap to 0
    for (int i = 0; i < 256; i++) imem[i] = 8'h00;
    imem[255] = 8'h3A;
    do_reset();
    for (int p = 0; p <= 254; p++)
      run_instr("w.nop", 8'(p), 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
    run_instr("undef3A", 8'd255, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 4'hA, 1'b0);
    run_instr("wrap0", 8'd0, 4'hA, 2'b00, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_control_unit.md
Name: cpu_control_unit

Overview:
Multi-cycle fetch/decode/execute sequencer for the 8-bit accumulator CPU. It owns the program counter, fetches from instruction memory, decodes the 4-bit opcode/4-bit operand format, and issues one-cycle control strobes to the accumulator/register-file datapath. It sits between the instruction memory port and the datapath inside Master_System.

Parameters:
PC_WIDTH, 8, program counter and instruction-address width
INSTR_WIDTH, 8, instruction word width (opcode = [7:4], operand = [3:0])
RESET_PC, 0, PC value loaded on reset

Ports:
CLK  input  1  system clock, rising edge
CLB  input  1  asynchronous active-low reset
instr_in  input  INSTR_WIDTH  instruction word from memory, valid same cycle as pc_out
acc_neg  input  1  datapath flag, ACC[7] (accumulator negative)
pc_out  output  PC_WIDTH  instruction memory address
alu_op  output  2  00 pass, 01 add, 10 sub, 11 shift-left-1
acc_we  output  1  accumulator write strobe
acc_src  output  1  0 = ALU result, 1 = zero-extended immediate
reg_we  output  1  register-file write strobe (reg <= ACC)
reg_sel  output  4  register index (operand field)
imm_out  output  4  immediate (operand field)
halted  output  1  high once HALT executes

Behaviour:
- Reset (CLB low, async): state=FETCH, PC=RESET_PC, ir=0, all strobes 0, alu_op=00, acc_src=0, reg_sel=0, imm_out=0, halted=0. Reset mid-instruction aborts it; no strobe is issued.
- States: FETCH -> DECODE -> EXECUTE -> FETCH; HALT is absorbing.
- FETCH: pc_out=PC; ir <= instr_in at the rising edge ending the cycle.
- DECODE: reg_sel/imm_out <= ir[3:0]; alu_op/acc_src are driven from the opcode; strobes stay 0.
- EXECUTE: exactly one cycle of strobes; PC updated at its end. CPI = 3.
- Opcodes:
  - 0000 NOP: no strobe.
  - 0001 ADD: alu_op=01, acc_we.
  - 0010 SUB: alu_op=10, acc_we.
  - 0101 STA: reg_we (reg[operand] <= ACC).
  - 1011 SHL: alu_op=11, acc_we.
  - 1101 LDI: acc_src=1, acc_we.
  - 1010 BRN: if acc_neg is sampled high in EXECUTE, PC <= zero-extended operand; else PC+1.
  - 1111 HALT: enter HALT.
  - All other opcodes: NOP.
- PC increments modulo 2^PC_WIDTH (255 -> 0, no trap). A branch target equal to the current PC is legal (tight loop).
- acc_neg is sampled only in EXECUTE of BRN. The datapath updates ACC at the EXECUTE edge, so a BRN directly after SUB sees the post-SUB value.
- HALT:
  - All strobes 0; pc_out holds the HALT address; halted=1.
  - Leaves only via CLB.
  - instr_in is ignored.
- acc_we and reg_we are never both high in the same cycle.

Decomposition:
- Shared package cpu_pkg:
  - Opcode localparams (OP_NOP, OP_ADD, OP_SUB, OP_STA, OP_BRN, OP_SHL, OP_LDI, OP_HALT).
  - ALU op encodings.
  - State encoding.
  - Instruction field slice positions.
- One natural sub-module: cpu_decoder. Purely combinational; maps opcode to {alu_op, acc_src, acc_we_en, reg_we_en, is_branch, is_halt}. The FSM and PC stay in the top module.

Test Plan:
- Reset:
  - Stimulus: assert CLB low mid-EXECUTE of an ADD.
  - Required response: all strobes drop immediately (async); pc_out=0, halted=0; after release, FETCH at PC=0.
- Sequencing:
  - Stimulus: stream LDI 5 (D5), STA r0 (50), LDI 3, STA r1, LDI 0, ADD r0 (10), SUB r1 (21).
  - Required response: acc_we/reg_we pulse once each, every 3rd cycle, with alu_op 01 then 10 and reg_sel 0 then 1; pc_out steps 0..6.
- Branch taken:
  - Stimulus: at PC=13 with acc_neg=1, execute AF.
  - Required response: next fetch pc_out=15; PC 14 is never fetched.
- Branch not taken:
  - Stimulus: same instruction AF with acc_neg=0.
  - Required response: next fetch pc_out=14.
- Halt and NOP:
  - Stimulus: NOP (00) x3, then F0, then 10 cycles of arbitrary instr_in.
  - Required response: NOPs produce no strobes; halted=1 from the HALT EXECUTE onward; pc_out frozen at 18; no strobes thereafter.
- Wrap and undefined opcode:
  - Stimulus: preload the PC near 255 via BRN chains/NOPs; 0x3A undefined opcode at 255.
  - Required response: treated as NOP; next pc_out=0.
